// File: rtl/text_pkg.sv
// Shared text-line constants for the line buffer and the VGA text renderer.
// Default banner and character helpers live here so both sides agree.
package text_pkg;

    localparam int TEXT_LEN = 16;
    localparam int TEXT_PW  = $clog2(TEXT_LEN);

    typedef logic [7:0] char_t;

    localparam char_t CHAR_SPACE = 8'h20;

    localparam logic [TEXT_LEN*8-1:0] DEFAULT_TEXT =
        "Driving IT 2025 ";

    typedef struct packed {
        logic wr;
        logic clr;
    } pin_evt_t;

    // Leftmost character of the literal sits in the top byte.
    function automatic char_t default_char(input int i);
        int k;
        k = i % TEXT_LEN;
        return DEFAULT_TEXT[(TEXT_LEN-1-k)*8 +: 8];
    endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with a rising-edge pulse.
// The pulse is one clock wide and derived from the synchronized level.
module pin_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise
);

    logic s1;
    logic s2;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= pin;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign rise = s2 & ~hist;

endmodule

// File: rtl/text_line_buffer.sv
// Writable, scrollable line store with a registered per-pixel character read.
// Pin writes auto-increment; marquee rotation advances on vsync frame events.
module text_line_buffer #(
    parameter int TEXT_LEN         = 16,
    parameter int SCROLL_DIV       = 8,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_strobe,
    input  logic                        wr_clear,
    input  logic                        scroll_en,
    input  logic                        vsync,
    input  logic [$clog2(TEXT_LEN):0]   rd_index,
    output logic [7:0]                  rd_char,
    output logic [$clog2(TEXT_LEN)-1:0] wr_ptr,
    output logic [$clog2(TEXT_LEN)-1:0] scroll_offset
);

    import text_pkg::*;

    localparam int PW = $clog2(TEXT_LEN);
    localparam logic [7:0] DIV_LAST = 8'(SCROLL_DIV - 1);

    char_t          mem [TEXT_LEN];
    pin_evt_t       evt;
    logic [PW-1:0]  wr_slot;
    logic [PW-1:0]  rd_slot;
    logic           vs_act;
    logic           vs_hist;
    logic           frame_evt;
    logic [7:0]     frame_cnt;

    pin_sync_edge u_wr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (wr_strobe),
        .rise  (evt.wr)
    );

    pin_sync_edge u_clr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (wr_clear),
        .rise  (evt.clr)
    );

    // A clear coinciding with a write redirects that write to slot 0.
    assign wr_slot = evt.clr ? '0 : wr_ptr;
    assign rd_slot = rd_index[PW-1:0] + scroll_offset;

    assign vs_act    = (VSYNC_ACTIVE_LOW != 0) ? ~vsync : vsync;
    assign frame_evt = vs_act & ~vs_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TEXT_LEN; i++) begin
                mem[i[PW-1:0]] <= default_char(i);
            end
        end else if (evt.wr) begin
            mem[wr_slot] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (evt.wr) begin
            wr_ptr <= wr_slot + 1'b1;
        end else if (evt.clr) begin
            wr_ptr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_hist       <= 1'b0;
            frame_cnt     <= '0;
            scroll_offset <= '0;
        end else begin
            vs_hist <= vs_act;
            if (scroll_en && frame_evt) begin
                if (frame_cnt == DIV_LAST) begin
                    frame_cnt     <= '0;
                    scroll_offset <= scroll_offset + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_char <= CHAR_SPACE;
        end else if (rd_index[PW]) begin
            rd_char <= CHAR_SPACE;
        end else begin
            rd_char <= mem[rd_slot];
        end
    end

endmodule

// File: tb/tb_text_line_buffer.sv
// Self-checking bench for text_line_buffer with a transaction-level model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_text_line_buffer;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       wr_clear;
    logic       scroll_en;
    logic       vsync;
    logic [4:0] rd_index;
    logic [7:0] rd_char;
    logic [3:0] wr_ptr;
    logic [3:0] scroll_offset;

    always #5 clk = ~clk;

    text_line_buffer #(
        .TEXT_LEN         (16),
        .SCROLL_DIV       (DIV),
        .VSYNC_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_data       (wr_data),
        .wr_strobe     (wr_strobe),
        .wr_clear      (wr_clear),
        .scroll_en     (scroll_en),
        .vsync         (vsync),
        .rd_index      (rd_index),
        .rd_char       (rd_char),
        .wr_ptr        (wr_ptr),
        .scroll_offset (scroll_offset)
    );

    typedef struct {
        logic [4:0] idx;
        logic [7:0] exp;
    } rd_vec_t;

    byte unsigned dflt [16] = '{
        8'h44, 8'h72, 8'h69, 8'h76, 8'h69, 8'h6E, 8'h67, 8'h20,
        8'h49, 8'h54, 8'h20, 8'h32, 8'h30, 8'h32, 8'h35, 8'h20
    };

    byte unsigned ref_mem [16];
    int ref_ptr;
    int ref_frames;
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int ref_off();
        return (ref_frames / DIV) % 16;
    endfunction

    function automatic int ref_read(input int idx);
        if (idx >= 16) return 32'h20;
        return int'(ref_mem[(idx + ref_off()) % 16]);
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = dflt[i];
        ref_ptr    = 0;
        ref_frames = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        tick(cycles);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic read_chk(input string name,
                            input logic [4:0] idx,
                            input logic [7:0] exp);
        rd_index = idx;
        tick(1);
        check(name, {24'd0, rd_char}, {24'd0, exp});
    endtask

    task automatic pulse(input logic [7:0] d, input logic clr);
        wr_data   = d;
        wr_strobe = 1'b1;
        wr_clear  = clr;
        tick(4);
        wr_strobe = 1'b0;
        wr_clear  = 1'b0;
        tick(4);
        if (clr) ref_ptr = 0;
        ref_mem[ref_ptr] = d;
        ref_ptr = (ref_ptr + 1) % 16;
    endtask

    task automatic clear_pulse();
        wr_clear = 1'b1;
        tick(4);
        wr_clear = 1'b0;
        tick(4);
        ref_ptr = 0;
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(2);
        if (scroll_en) ref_frames++;
    endtask

    task automatic check_state(input string name);
        check({name, "_ptr"}, {28'd0, wr_ptr}, ref_ptr);
        check({name, "_off"}, {28'd0, scroll_offset}, ref_off());
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < 16; i++) begin
            read_chk(name, 5'(i), 8'(ref_read(i)));
        end
        check_state(name);
    endtask

    rd_vec_t vt [18];

    initial begin
        for (int i = 0; i < 18; i++) begin
            vt[i].idx = 5'(i);
            vt[i].exp = (i < 16) ? dflt[i] : 8'h20;
        end

        rst_n     = 1'b0;
        wr_data   = 8'h00;
        wr_strobe = 1'b0;
        wr_clear  = 1'b0;
        scroll_en = 1'b0;
        vsync     = 1'b1;
        rd_index  = 5'd0;
        @(negedge clk);
        do_reset(3);

        check("rst_rd_char", {24'd0, rd_char}, 32'h20);
        check_state("rst");

        for (int i = 0; i < 18; i++) begin
            read_chk("rst_table", vt[i].idx, vt[i].exp);
        end

        // Exact write latency, including the old value on a same-slot read.
        rd_index  = 5'd0;
        wr_data   = 8'h41;
        wr_strobe = 1'b1;
        tick(1);
        check("lat_n0", {24'd0, rd_char}, 32'h44);
        tick(2);
        check("lat_old", {24'd0, rd_char}, 32'h44);
        tick(1);
        check("lat_new", {24'd0, rd_char}, 32'h41);
        wr_strobe = 1'b0;
        tick(4);
        ref_mem[0] = 8'h41;
        ref_ptr    = 1;
        pulse(8'h42, 1'b0);
        pulse(8'h43, 1'b0);
        check_all("wr3");

        clear_pulse();
        check_state("clr");
        for (int i = 0; i < 17; i++) pulse(8'(8'h5A + i), 1'b0);
        check_all("wrap");
        check("wrap_ptr1", {28'd0, wr_ptr}, 32'd1);

        pulse(8'h7E, 1'b1);
        read_chk("clrwr_slot0", 5'd0, 8'h7E);
        check("clrwr_ptr", {28'd0, wr_ptr}, 32'd1);
        check_all("clrwr");

        do_reset(1);
        scroll_en = 1'b1;
        repeat (16) frame();
        check("scr_off2", {28'd0, scroll_offset}, 32'd2);
        read_chk("scr_rd0", 5'd0, 8'h69);
        read_chk("scr_rd17", 5'd17, 8'h20);
        scroll_en = 1'b0;
        repeat (8) frame();
        check("scr_hold", {28'd0, scroll_offset}, 32'd2);
        scroll_en = 1'b1;
        repeat (128) frame();
        check("scr_wrap", {28'd0, scroll_offset}, 32'd2);
        repeat (5) frame();
        check_all("scr_part");

        for (int it = 0; it < 300; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                pulse(8'($urandom_range(0, 255)),
                      ($urandom_range(0, 5) == 0));
            end else if (op == 4) begin
                clear_pulse();
            end else if (op <= 6) begin
                scroll_en = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 12)) frame();
            end else begin
                int idx;
                idx = $urandom_range(0, 31);
                read_chk("rnd_rd", 5'(idx), 8'(ref_read(idx)));
                check_state("rnd");
            end
        end
        check_all("rnd_end");

        do_reset(1);
        check("mid_rst_rd", {24'd0, rd_char}, 32'h20);
        check_state("mid_rst");
        check_all("mid_rst_mem");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/text_line_buffer.md
# text_line_buffer

Writable, scrollable 16-character line store feeding the VGA text renderer. It holds the displayed string, which resets to "Driving IT 2025 ". It accepts character writes from the dedicated input pins through a synchronized strobe with an auto-incrementing pointer. It serves the renderer's per-pixel character lookup with a one-cycle registered read, and can rotate the line as a marquee at a frame-locked rate.

## Interface
- `TEXT_LEN`, 16: characters stored; must be a power of two.
- `SCROLL_DIV`, 8: frames per one-character scroll step; legal range 1..255.
- `VSYNC_ACTIVE_LOW`, 1: polarity of `vsync`; 1 means active-low (640x480 VGA).
- `clk` input 1: pixel clock, 25.175 MHz.
- `rst_n` input 1: synchronous, active-low reset.
- `wr_data` input 8: ASCII code to write; pin-driven.
- `wr_strobe` input 1: asynchronous pin; a rising edge requests one write.
- `wr_clear` input 1: asynchronous pin; a rising edge returns the write pointer to 0.
- `scroll_en` input 1: level; 1 enables marquee advance.
- `vsync` input 1: from the sync generator, same clock domain.
- `rd_index` input 5: character slot requested by the renderer.
- `rd_char` output 8: registered character for `rd_index` (+ scroll).
- `wr_ptr` output 4: next write slot.
- `scroll_offset` output 4: current rotation amount.

## Operation
- Storage is 16 × 8 flops. At reset the contents load the default string: 44 72 69 76 69 6E 67 20 49 54 20 32 30 32 35 20.
- Pin inputs `wr_strobe` and `wr_clear` each pass through a 2-flop synchronizer plus a history flop. Edge = sync & ~history.
- Write edge: `mem[wr_ptr]` <= `wr_data`, then `wr_ptr` <= `wr_ptr`+1, which wraps from 15 to 0.
- Clear edge alone: `wr_ptr` <= 0. Memory is not touched.
- Clear and write edge in the same cycle: the write goes to slot 0 and `wr_ptr` becomes 1.
- Frame event: the first cycle in which `vsync` reaches its active level. It is edge-detected with one history flop, with no synchronizer.
- Frame counter (8 bit) runs only while `scroll_en`=1:
  - On each frame event, if counter = `SCROLL_DIV`−1, it clears and `scroll_offset` increments mod 16.
  - Otherwise the counter increments.
- `scroll_en`=0 freezes both the counter and `scroll_offset`. Neither is cleared.
- Read: if `rd_index` < 16, `rd_char` <= `mem[(rd_index[3:0] + scroll_offset) mod 16]`. Otherwise `rd_char` <= 8'h20.
- Read and write of the same slot in the same cycle: the read returns the old value.
- Reset mid-operation: contents, pointers, counters and sync flops all return to their reset values. A write in flight is lost.

## Timing
- Reset values:
  - `rd_char` = 8'h20
  - `wr_ptr` = 0
  - `scroll_offset` = 0
  - frame counter = 0
  - all sync and history flops = 0
- Read latency: 1 cycle. `rd_index` applied before edge N gives `rd_char` valid after edge N. The renderer requests the index for pixel x+1.
- Write latency:
  - `wr_strobe` first sampled high at edge N → edge detected after N+1.
  - Memory and `wr_ptr` updated at edge N+2.
  - New character visible on `rd_char` after N+3.
- `wr_data` must be stable from the strobe rise until 3 clocks later.
- Strobe high and low phases must each be at least 3 clocks. Shorter pulses may be missed.
- `scroll_offset` changes one clock after the frame event cycle, during vertical blanking, so no visible tearing.

## Structure
- Shared package `text_pkg` holds:
  - `TEXT_LEN`
  - `CHAR_SPACE` = 8'h20
  - `DEFAULT_TEXT` constant (16 × 8)
- The renderer uses the same constants.
- One sub-module, `pin_sync_edge`: 2-flop synchronizer + rising-edge pulse with sync active-low reset. It is instantiated for `wr_strobe` and `wr_clear`.
- The vsync edge detector is inline.

## Test plan
- Reset, then read `rd_index` 0..17 → "Driving IT 2025 " codes at 0..15, 8'h20 at 16 and 17, each one cycle after the request. `wr_ptr`=0.
- Pulse `wr_strobe` (4 clk high, 4 low) with `wr_data` 41,42,43 → slots 0..2 read 41,42,43, `wr_ptr`=3. The first write is visible exactly 3 cycles after the strobe is sampled high.
- 17 writes of 8'h5A..8'h6A → `wr_ptr` wraps to 1 and slot 0 holds 8'h6A.
- Raise `wr_clear` and `wr_strobe` in the same cycle with data 8'h7E → slot 0 = 8'h7E and `wr_ptr`=1.
- `scroll_en`=1, `SCROLL_DIV`=8, drive 16 frames → `scroll_offset`=2 and `rd_index`=0 returns 8'h69.
  - Drop `scroll_en` for 8 frames → the offset holds at 2.
  - 8×16 further enabled frames → the offset wraps back to 2.
- Assert `rst_n`=0 for one cycle after writes and scrolling → all outputs return to reset values and the default string is restored.
